// File: rtl/pool_scheduler_if.sv
// ============================================================================
// Module   : pool_scheduler_if
// Brief    : Bundle of the pool, writeback and exec-port signals around the
//            pool scheduler. The master side drives the pool and writebacks;
//            the slave side is the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pool_scheduler_if #(
    parameter int PNUMS = 2
);
    localparam int SW = (PNUMS > 1) ? $clog2(PNUMS) : 1;

    logic                  FLUSH;
    logic                  MMU_WAIT;
    logic [32*PNUMS-1:0]   POOL_PC;
    logic [17*PNUMS-1:0]   POOL_OPCODE;
    logic [5*PNUMS-1:0]    POOL_RD;
    logic [5*PNUMS-1:0]    POOL_RS1;
    logic [5*PNUMS-1:0]    POOL_RS2;
    logic [32*PNUMS-1:0]   POOL_RINST;
    logic                  WB_VALID;
    logic [4:0]            WB_RD;
    logic                  SCHED_STALL;
    logic                  EXEC_VALID;
    logic                  EXEC_READY;
    logic [SW-1:0]         EXEC_SLOT;
    logic [31:0]           EXEC_PC;
    logic [16:0]           EXEC_OPCODE;
    logic [4:0]            EXEC_RD;
    logic [4:0]            EXEC_RS1;
    logic [4:0]            EXEC_RS2;
    logic [31:0]           EXEC_RINST;

    modport master (
        output FLUSH, MMU_WAIT, POOL_PC, POOL_OPCODE, POOL_RD, POOL_RS1, POOL_RS2,
               POOL_RINST, WB_VALID, WB_RD, EXEC_READY,
        input  SCHED_STALL, EXEC_VALID, EXEC_SLOT, EXEC_PC, EXEC_OPCODE,
               EXEC_RD, EXEC_RS1, EXEC_RS2, EXEC_RINST
    );

    modport slave (
        input  FLUSH, MMU_WAIT, POOL_PC, POOL_OPCODE, POOL_RD, POOL_RS1, POOL_RS2,
               POOL_RINST, WB_VALID, WB_RD, EXEC_READY,
        output SCHED_STALL, EXEC_VALID, EXEC_SLOT, EXEC_PC, EXEC_OPCODE,
               EXEC_RD, EXEC_RS1, EXEC_RS2, EXEC_RINST
    );
endinterface

`default_nettype wire

// File: rtl/pool_scheduler.sv
// ============================================================================
// Module   : pool_scheduler
// Brief    : Scheduler stage 1. Picks the lowest-index hazard-free pool slot,
//            issues it to a registered exec port and stalls the pool until
//            every valid slot has issued. Optional macro SCHED_WB_BYPASS_EN
//            lets a same-cycle writeback release a hazard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_scheduler #(
    parameter int COP_NUMS = 1,
    parameter int PNUMS    = COP_NUMS + 1
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    pool_scheduler_if.slave   bus
);
    localparam int          SW       = (PNUMS > 1) ? $clog2(PNUMS) : 1;
    localparam logic [31:0] C_NOP    = 32'h0000_0013;
    localparam logic [31:0] C_EMPTY  = 32'hFFFF_FFFF;

    logic              exec_valid_q, exec_valid_d;
    logic [SW-1:0]     exec_slot_q,  exec_slot_d;
    logic [31:0]       exec_pc_q,    exec_pc_d;
    logic [16:0]       exec_op_q,    exec_op_d;
    logic [4:0]        exec_rd_q,    exec_rd_d;
    logic [4:0]        exec_rs1_q,   exec_rs1_d;
    logic [4:0]        exec_rs2_q,   exec_rs2_d;
    logic [31:0]       exec_ri_q,    exec_ri_d;
    logic [31:0]       busy_q,       busy_d;
    logic [PNUMS-1:0]  done_q,       done_d;

    logic [31:0]       w_wb_clr;
    logic [31:0]       w_busy_chk;
    logic [PNUMS-1:0]  w_slot_vld;
    logic [PNUMS-1:0]  w_elig;
    logic [PNUMS-1:0]  w_onehot;
    logic [PNUMS-1:0]  w_issued;
    logic [PNUMS-1:0]  w_pending;
    logic              w_any;
    logic [SW-1:0]     w_sel;
    logic [31:0]       w_sel_pc;
    logic [16:0]       w_sel_op;
    logic [4:0]        w_sel_rd;
    logic [4:0]        w_sel_rs1;
    logic [4:0]        w_sel_rs2;
    logic [31:0]       w_sel_ri;
    logic              w_free;
    logic              w_issue_en;
    logic              w_do_issue;
    logic              w_stall;

    assign w_wb_clr = (bus.WB_VALID && (bus.WB_RD != 5'd0)) ? (32'd1 << bus.WB_RD) : 32'd0;

`ifdef SCHED_WB_BYPASS_EN
    assign w_busy_chk = busy_q & ~w_wb_clr;
`else
    assign w_busy_chk = busy_q;
`endif

    // Descending scan so the last match written is the lowest eligible index.
    always_comb begin
        w_slot_vld = '0;
        w_elig     = '0;
        w_onehot   = '0;
        w_any      = 1'b0;
        w_sel      = '0;
        w_sel_pc   = '0;
        w_sel_op   = '0;
        w_sel_rd   = '0;
        w_sel_rs1  = '0;
        w_sel_rs2  = '0;
        w_sel_ri   = '0;
        for (int k = PNUMS - 1; k >= 0; k--) begin
            w_slot_vld[k] = (bus.POOL_RINST[32*k +: 32] != C_EMPTY);
            w_elig[k]     = w_slot_vld[k] && !done_q[k]
                            && !w_busy_chk[bus.POOL_RS1[5*k +: 5]]
                            && !w_busy_chk[bus.POOL_RS2[5*k +: 5]]
                            && !w_busy_chk[bus.POOL_RD[5*k +: 5]];
            if (w_elig[k]) begin
                w_any       = 1'b1;
                w_sel       = SW'(k);
                w_onehot    = '0;
                w_onehot[k] = 1'b1;
                w_sel_pc    = bus.POOL_PC[32*k +: 32];
                w_sel_op    = bus.POOL_OPCODE[17*k +: 17];
                w_sel_rd    = bus.POOL_RD[5*k +: 5];
                w_sel_rs1   = bus.POOL_RS1[5*k +: 5];
                w_sel_rs2   = bus.POOL_RS2[5*k +: 5];
                w_sel_ri    = bus.POOL_RINST[32*k +: 32];
            end
        end
    end

    assign w_free     = !exec_valid_q || bus.EXEC_READY;
    assign w_issue_en = w_free && !bus.MMU_WAIT && !bus.FLUSH;
    assign w_do_issue = w_issue_en && w_any;
    assign w_issued   = w_do_issue ? w_onehot : '0;
    assign w_pending  = w_slot_vld & ~done_q & ~w_issued;
    assign w_stall    = !bus.FLUSH && (bus.MMU_WAIT || (|w_pending));

    always_comb begin
        exec_valid_d = exec_valid_q;
        exec_slot_d  = exec_slot_q;
        exec_pc_d    = exec_pc_q;
        exec_op_d    = exec_op_q;
        exec_rd_d    = exec_rd_q;
        exec_rs1_d   = exec_rs1_q;
        exec_rs2_d   = exec_rs2_q;
        exec_ri_d    = exec_ri_q;
        busy_d       = busy_q & ~w_wb_clr;
        done_d       = w_stall ? (done_q | w_issued) : '0;

        // Issue set is applied after the writeback clear so it wins on a tie.
        if (w_do_issue && (w_sel_rd != 5'd0)) begin
            busy_d[w_sel_rd] = 1'b1;
        end

        if (bus.FLUSH) begin
            exec_valid_d = 1'b0;
            exec_slot_d  = '0;
            exec_pc_d    = '0;
            exec_op_d    = '0;
            exec_rd_d    = '0;
            exec_rs1_d   = '0;
            exec_rs2_d   = '0;
            exec_ri_d    = C_NOP;
            busy_d       = '0;
            done_d       = '0;
        end else if (w_issue_en) begin
            exec_valid_d = w_any;
            if (w_any) begin
                exec_slot_d = w_sel;
                exec_pc_d   = w_sel_pc;
                exec_op_d   = w_sel_op;
                exec_rd_d   = w_sel_rd;
                exec_rs1_d  = w_sel_rs1;
                exec_rs2_d  = w_sel_rs2;
                exec_ri_d   = w_sel_ri;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            exec_valid_q <= 1'b0;
            exec_slot_q  <= '0;
            exec_pc_q    <= '0;
            exec_op_q    <= '0;
            exec_rd_q    <= '0;
            exec_rs1_q   <= '0;
            exec_rs2_q   <= '0;
            exec_ri_q    <= C_NOP;
            busy_q       <= '0;
            done_q       <= '0;
        end else begin
            exec_valid_q <= exec_valid_d;
            exec_slot_q  <= exec_slot_d;
            exec_pc_q    <= exec_pc_d;
            exec_op_q    <= exec_op_d;
            exec_rd_q    <= exec_rd_d;
            exec_rs1_q   <= exec_rs1_d;
            exec_rs2_q   <= exec_rs2_d;
            exec_ri_q    <= exec_ri_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.SCHED_STALL = w_stall;
    assign bus.EXEC_VALID  = exec_valid_q;
    assign bus.EXEC_SLOT   = exec_slot_q;
    assign bus.EXEC_PC     = exec_pc_q;
    assign bus.EXEC_OPCODE = exec_op_q;
    assign bus.EXEC_RD     = exec_rd_q;
    assign bus.EXEC_RS1    = exec_rs1_q;
    assign bus.EXEC_RS2    = exec_rs2_q;
    assign bus.EXEC_RINST  = exec_ri_q;

endmodule

`default_nettype wire
